// File: rtl/score_argmax_if.sv
// Handshake bundle for score_argmax: packed scores in with valid/ready,
// classification result out with valid/ready, plus a busy indicator.
interface score_argmax_if #(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 16,
   parameter int IDX_W     = 4
);
   logic [N_CLASSES*SCORE_W-1:0] scores_in;
   logic                         in_valid;
   logic                         in_ready;
   logic                         out_valid;
   logic                         out_ready;
   logic [IDX_W-1:0]             digit;
   logic [SCORE_W-1:0]           max_score;
   logic [SCORE_W-1:0]           margin;
   logic                         busy;

   // Producer/consumer side (drives scores, consumes result)
   modport master (
      output scores_in, in_valid, out_ready,
      input  in_ready, out_valid, digit, max_score, margin, busy
   );

   // Argmax block side
   modport slave (
      input  scores_in, in_valid, out_ready,
      output in_ready, out_valid, digit, max_score, margin, busy
   );
endinterface

// File: rtl/score_argmax.sv
// Sequential argmax over N_CLASSES packed signed Q8.8 scores, one per cycle.
// Ports: clk, rst (sync, active high), bus (slave: scores/valid/ready in,
// digit/max_score/margin/out_valid out, busy).
module score_argmax #(
   parameter int N_CLASSES = 10,
   parameter int SCORE_W   = 16,
   parameter int IDX_W     = 4,
   parameter bit ONE_SHOT  = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   score_argmax_if.slave  bus
);

   localparam int VEC_W = N_CLASSES * SCORE_W;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD
   } state_t;

   state_t                     state;
   logic [VEC_W-1:0]           scores_q;
   logic [IDX_W-1:0]           idx;
   logic [IDX_W-1:0]           bidx;
   logic signed [SCORE_W-1:0]  best;
   logic signed [SCORE_W-1:0]  second;
   logic                       blocked;

   logic [IDX_W-1:0]           digit_q;
   logic [SCORE_W-1:0]         max_q;
   logic [SCORE_W-1:0]         margin_q;
   logic                       out_valid_q;

   logic signed [SCORE_W-1:0]  cur;
   logic signed [SCORE_W-1:0]  best_n;
   logic signed [SCORE_W-1:0]  second_n;
   logic [IDX_W-1:0]           bidx_n;
   logic [SCORE_W-1:0]         margin_n;
   logic                       last;
   logic                       in_ready;
   logic                       accept;

   assign in_ready = (state == IDLE) && !blocked;
   assign accept   = bus.in_valid && in_ready;
   assign last     = (idx == IDX_W'(N_CLASSES - 1));

   // Running best/runner-up update for the score at idx
   always_comb begin
      cur      = scores_q[int'(idx)*SCORE_W +: SCORE_W];
      best_n   = best;
      second_n = second;
      bidx_n   = bidx;
      if (idx == '0) begin
         best_n   = cur;
         bidx_n   = '0;
         second_n = {1'b1, {(SCORE_W-1){1'b0}}};
      end else if (cur > best) begin
         second_n = best;
         best_n   = cur;
         bidx_n   = idx;
      end else if (cur > second) begin
         second_n = cur;
      end
      // best >= second, so the true difference lies in [0, 2^SCORE_W-1]
      // and the modulo result is exact.
      margin_n = best_n - second_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         scores_q    <= '0;
         idx         <= '0;
         bidx        <= '0;
         best        <= '0;
         second      <= '0;
         blocked     <= 1'b0;
         digit_q     <= '0;
         max_q       <= '0;
         margin_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (!bus.in_valid)
            blocked <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  scores_q <= bus.scores_in;
                  idx      <= '0;
                  if (ONE_SHOT)
                     blocked <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               best   <= best_n;
               second <= second_n;
               bidx   <= bidx_n;
               idx    <= idx + 1'b1;
               if (last) begin
                  digit_q     <= bidx_n;
                  max_q       <= best_n;
                  margin_q    <= margin_n;
                  out_valid_q <= 1'b1;
                  idx         <= '0;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.digit     = digit_q;
   assign bus.max_score = max_q;
   assign bus.margin    = margin_q;

endmodule
